// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto a single async SRAM port.
// Define ARB_ROUND_ROBIN_EN to alternate grants; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    mem_cs_q, mem_cs_d;
    logic                    mem_we_q, mem_we_d;
    logic                    mem_oe_q, mem_oe_d;
    logic                    drive_q, drive_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic                    win;
    logic                    win_we;

`ifdef ARB_ROUND_ROBIN_EN
    // Holds the id of the last requester granted; reset to 1 so requester 0 goes first.
    logic last_q, last_d;

    always_comb begin
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
    end
`else
    always_comb begin
        win = ~req0;
    end
`endif

    assign win_we = win ? we1 : we0;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_cs_d   = mem_cs_q;
        mem_we_d   = mem_we_q;
        mem_oe_d   = mem_oe_q;
        drive_d    = drive_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d    = ST_ACCESS;
                    gnt_d      = win;
                    mem_addr_d = win ? addr1 : addr0;
                    wdata_d    = win ? wdata1 : wdata0;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = win_we;
                    mem_oe_d   = ~win_we;
                    drive_d    = win_we;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d     = win;
`endif
                end
            end
            ST_ACCESS: begin
                // The RAM's read data is valid by the end of the single access cycle.
                if (!mem_we_q) begin
                    rdata_d = mem_data;
                end
                state_d  = ST_DONE;
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                mem_oe_d = 1'b0;
                drive_d  = 1'b0;
                done0_d  = ~gnt_q;
                done1_d  = gnt_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                mem_oe_d = 1'b0;
                drive_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            drive_q    <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_cs_q   <= mem_cs_d;
            mem_we_q   <= mem_we_d;
            mem_oe_q   <= mem_oe_d;
            drive_q    <= drive_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    // drive_q is only ever set together with mem_we, so the bus is never driven while mem_oe is high.
    assign mem_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign mem_addr = mem_addr_q;
    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_oe   = mem_oe_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural SRAM.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [23:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        done0, done1, busy;
    logic [15:0] rdata;
    logic [23:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_cs, mem_we, mem_oe;

    int tests_run;
    int tests_failed;
    int cs_pulses;
    int done_pulses;
    logic cs_prev;
    logic [15:0] ram [0:4095];

    mem_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram[mem_addr[11:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr[11:0]] <= mem_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("oe_we_excl", {31'd0, mem_oe & mem_we}, 32'd0);
            check("cs_one_cycle", {31'd0, mem_cs & cs_prev}, 32'd0);
            if (mem_cs && mem_oe) check("rd_bus", {16'd0, mem_data}, {16'd0, ram[mem_addr[11:0]]});
            if (mem_cs && !cs_prev) cs_pulses++;
            if (done0 || done1) done_pulses++;
            cs_prev = mem_cs;
        end else begin
            cs_prev = 1'b0;
        end
    end

    task automatic access(input bit id, input bit we, input logic [23:0] a, input logic [15:0] d,
                          output logic [15:0] rd);
        int  n;
        bit  seen;
        @(negedge clk);
        if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        n = 0;
        seen = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (id ? done1 : done0) seen = 1;
        end
        check("latency", n, 2);
        check("other_done", {31'd0, id ? done0 : done1}, 32'd0);
        rd = rdata;
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    logic [15:0] rd;
    int          last_done;
    int          cyc;
    logic        exp_ids [4];
    logic [15:0] b2b_data [3];

    initial begin
        tests_run = 0; tests_failed = 0; cs_pulses = 0; done_pulses = 0; cs_prev = 1'b0;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        check("rst_cs", {31'd0, mem_cs}, 0);
        check("rst_we_oe", {30'd0, mem_we, mem_oe}, 0);
        check("rst_addr", {8'd0, mem_addr}, 0);
        check("rst_busy_done", {29'd0, busy, done0, done1}, 0);
        check("rst_rdata", {16'd0, rdata}, 0);
        rst = 1'b0;

        // Single write then read.
        access(0, 1, 24'h000123, 16'hBEEF, rd);
        access(0, 0, 24'h000123, 16'h0000, rd);
        check("wr_rd_beef", {16'd0, rd}, 32'hBEEF);

        // Preload for arbitration test; a write must not disturb rdata.
        access(0, 1, 24'h000300, 16'h1111, rd);
        check("rdata_kept_on_wr", {16'd0, rd}, 32'hBEEF);
        access(1, 1, 24'h000301, 16'h2222, rd);

        // Back-to-back writes with req1 held.
        b2b_data[0] = 16'h0001; b2b_data[1] = 16'h0002; b2b_data[2] = 16'h0003;
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 24'h0000A0; wdata1 = b2b_data[0];
        cyc = 0; last_done = -1;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            while (!done1 && n < 10) begin @(negedge clk); cyc++; n++; end
            check("b2b_done", {31'd0, done1}, 1);
            if (k > 0) check("b2b_spacing", cyc - last_done, 3);
            last_done = cyc;
            if (k < 2) begin addr1 = 24'h0000A1 + k; wdata1 = b2b_data[k+1]; end
            else req1 = 0;
            @(negedge clk); cyc++;
        end
        for (int k = 0; k < 3; k++) begin
            access(1, 0, 24'h0000A0 + k, 16'h0000, rd);
            check("b2b_readback", {16'd0, rd}, {16'd0, b2b_data[k]});
        end

        // Reset during the ACCESS cycle of a write.
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 24'h000010; wdata0 = 16'h1234;
        @(negedge clk);
        check("abort_in_access", {31'd0, mem_cs}, 1);
        rst = 1'b1;
        #1;
        check("abort_cs_we_oe", {29'd0, mem_cs, mem_we, mem_oe}, 0);
        check("abort_addr", {8'd0, mem_addr}, 0);
        check("abort_busy_done", {29'd0, busy, done0, done1}, 0);
        check("abort_rdata", {16'd0, rdata}, 0);
        req0 = 0;
        @(negedge clk);
        rst = 1'b0;
        begin
            logic any_done;
            any_done = 0;
            repeat (4) begin @(negedge clk); any_done |= done0 | done1; end
            check("abort_no_done", {31'd0, any_done}, 0);
        end

        // Simultaneous reads from reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 0; exp_ids[3] = 1;
`else
        exp_ids[0] = 0; exp_ids[1] = 0; exp_ids[2] = 0; exp_ids[3] = 0;
`endif
        req0 = 1; we0 = 0; addr0 = 24'h000300;
        req1 = 1; we1 = 0; addr1 = 24'h000301;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!(done0 || done1) && n < 10);
            check("sim_done_seen", {31'd0, done0 | done1}, 1);
            check("sim_grant", {31'd0, done1}, {31'd0, exp_ids[k]});
            check("sim_rdata", {16'd0, rdata}, done1 ? 32'h2222 : 32'h1111);
        end
        req0 = 0; req1 = 0;
        repeat (4) @(negedge clk);

        check("cs_vs_done", cs_pulses, done_pulses + 1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
